// File: rtl/ex_div_ctrl_pkg.sv
// ex_div_ctrl_pkg: shared types and constants for the EX-stage divide
// sequencer. Provides the FSM state type, start/ready encodings and the
// double-width result bus type used by the HI/LO write path.
package ex_div_ctrl_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    // Divider sequencer states: free (idle), divide-by-zero, running, end
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef logic [2*DIV_DATA_W-1:0] double_reg_bus_t;

endpackage

// File: rtl/ex_div_ctrl_if.sv
// ex_div_ctrl_if: EX-stage <-> divider handshake.
//   start_i      EX requests a divide (held until ready_o)
//   signed_i     1 = DIV, 0 = DIVU
//   opdata1_i    dividend
//   opdata2_i    divisor
//   annul_i      flush, aborts the divide in progress
//   result_o     {remainder, quotient} -> {HI, LO}
//   ready_o      result_o valid
//   stall_req_o  combinational stall request to the pipeline controller
// master = EX stage, slave = divider.
interface ex_div_ctrl_if #(
    parameter int DATA_W = 32
);
    logic                  start_i;
    logic                  signed_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stall_req_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, stall_req_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, stall_req_o
    );
endinterface

// File: rtl/ex_div_step.sv
// ex_div_step: one combinational radix-2 restoring-divide iteration.
//   rem_i  partial remainder
//   quo_i  dividend bits still to consume (MSB first), quotient bits shift in at LSB
//   dvs_i  divisor (magnitude)
//   rem_o  next partial remainder
//   quo_o  next dividend/quotient shift register
module ex_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;
    logic            trial_neg;

    // shifted < 2*divisor always holds, so the (DATA_W+1)-bit difference
    // never wraps past its sign bit: MSB set means the subtraction borrowed.
    always_comb begin
        shifted   = {rem_i, quo_i[DATA_W-1]};
        trial     = shifted - {1'b0, dvs_i};
        trial_neg = trial[DATA_W];
        rem_o     = trial_neg ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_o     = {quo_i[DATA_W-2:0], ~trial_neg};
    end
endmodule

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle DIV/DIVU sequencer for the EX stage.
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   div   slave side of ex_div_ctrl_if (start/operands/annul in,
//         result/ready/stall out)
// A start accepted in IDLE runs DATA_W restoring iterations; the
// sign-corrected {remainder, quotient} is then held on result_o with
// ready_o high until EX drops start_i. Divide by zero returns 0.
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    ex_div_ctrl_if.slave     div
);
    localparam int MSB = DATA_W - 1;

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                sign_q_q, sign_q_d;
    logic                sign_r_q, sign_r_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W-1:0]   step_rem, step_quo;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    ex_div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        quo_fix = sign_q_q ? (~quo_q + DATA_W'(1)) : quo_q;
        rem_fix = sign_r_q ? (~rem_q + DATA_W'(1)) : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        result_d = result_q;
        ready_d  = ready_q;

        unique case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if (div.start_i == DIV_START && !div.annul_i) begin
                    if (div.opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        // |x| of the most negative value wraps to itself,
                        // which read as unsigned is exactly 2^(DATA_W-1).
                        quo_d    = (div.signed_i && div.opdata1_i[MSB]) ?
                                   (~div.opdata1_i + DATA_W'(1)) : div.opdata1_i;
                        dvs_d    = (div.signed_i && div.opdata2_i[MSB]) ?
                                   (~div.opdata2_i + DATA_W'(1)) : div.opdata2_i;
                        rem_d    = '0;
                        sign_q_d = div.signed_i & (div.opdata1_i[MSB] ^ div.opdata2_i[MSB]);
                        sign_r_d = div.signed_i & div.opdata1_i[MSB];
                        cnt_d    = '0;
                        state_d  = DIV_ON;
                    end
                end
            end
            DIV_BY_ZERO: begin
                if (div.annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    rem_d    = '0;
                    quo_d    = '0;
                    sign_q_d = 1'b0;
                    sign_r_d = 1'b0;
                    state_d  = DIV_END;
                end
            end
            DIV_ON: begin
                if (div.annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    // Leave on the edge that completes the last iteration;
                    // DIV_END then publishes the corrected result on the next
                    // edge, which puts ready_o after edge DATA_W+1.
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = DIV_END;
                    end
                end
            end
            DIV_END: begin
                if (div.annul_i || div.start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else begin
                    ready_d  = DIV_RESULT_READY;
                    result_d = {rem_fix, quo_fix};
                end
            end
            default: state_d = DIV_FREE;
        endcase

        // Aborting from any busy state drops whatever was being presented.
        if (div.annul_i && state_q != DIV_FREE) begin
            ready_d  = DIV_RESULT_NOT_READY;
            result_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign div.result_o    = result_q;
    assign div.ready_o     = ready_q;
    assign div.stall_req_o = div.start_i & ~ready_q & ~div.annul_i;

endmodule
